// File: rtl/ad_emu_pkg.sv
// Shared constants for the ADC emulator: register map, mode and state encodings.
package ad_emu_pkg;

  localparam int unsigned FRAME_W = 16;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_CONST_LO  = 8'h01;
  localparam logic [7:0] REG_CONST_HI  = 8'h02;
  localparam logic [7:0] REG_STEP_LO   = 8'h03;
  localparam logic [7:0] REG_STEP_HI   = 8'h04;
  localparam logic [7:0] REG_ALT_LO    = 8'h05;
  localparam logic [7:0] REG_ALT_HI    = 8'h06;
  localparam logic [7:0] REG_FRAME_CNT = 8'h07;
  localparam logic [7:0] REG_STATUS    = 8'h08;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ad_emu_regs.sv
// fx bus register file for the ADC emulator; also owns the pattern word and frame counter.
module ad_emu_regs
  import ad_emu_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [5:0]           dev_id,
  input  logic [21:0]          fx_waddr,
  input  logic                 fx_wr,
  input  logic [7:0]           fx_data,
  input  logic [21:0]          fx_raddr,
  input  logic                 fx_rd,
  output logic [7:0]           fx_q,
  input  state_t               state,
  input  logic                 frame_done,
  output logic                 en,
  output logic [FRAME_W-1:0]   cur_word
);

  mode_t              mode;
  logic [FRAME_W-1:0] const_val;
  logic [FRAME_W-1:0] step;
  logic [FRAME_W-1:0] alt_val;
  logic [7:0]         frame_cnt;
  logic               sq_phase;
  logic               wr_hit;
  logic               rd_hit;
  logic               ctrl_wr;
  logic               unused_addr;

  assign wr_hit      = fx_wr && (fx_waddr[21:16] == dev_id);
  assign rd_hit      = fx_rd && (fx_raddr[21:16] == dev_id);
  assign ctrl_wr     = wr_hit && (fx_waddr[7:0] == REG_CTRL);
  assign unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      en        <= 1'b0;
      mode      <= MODE_CONST;
      const_val <= '0;
      step      <= '0;
      alt_val   <= '0;
      frame_cnt <= '0;
      sq_phase  <= 1'b0;
      cur_word  <= '0;
      fx_q      <= '0;
    end else begin
      if (wr_hit) begin
        case (fx_waddr[7:0])
          REG_CTRL: begin
            en   <= fx_data[0];
            mode <= mode_t'(fx_data[2:1]);
          end
          REG_CONST_LO: const_val[7:0]  <= fx_data;
          REG_CONST_HI: const_val[15:8] <= fx_data;
          REG_STEP_LO:  step[7:0]       <= fx_data;
          REG_STEP_HI:  step[15:8]      <= fx_data;
          REG_ALT_LO:   alt_val[7:0]    <= fx_data;
          REG_ALT_HI:   alt_val[15:8]   <= fx_data;
          default: ;
        endcase
      end

      if (frame_done)
        frame_cnt <= frame_cnt + 8'd1;

      // A ctrl write takes priority over a frame completing in the same cycle.
      if (ctrl_wr) begin
        cur_word <= const_val;
        sq_phase <= 1'b0;
      end else if (frame_done) begin
        case (mode)
          MODE_RAMP: cur_word <= cur_word + step;
          MODE_SQUARE: begin
            cur_word <= sq_phase ? const_val : alt_val;
            sq_phase <= ~sq_phase;
          end
          default: cur_word <= const_val;
        endcase
      end

      if (rd_hit) begin
        case (fx_raddr[7:0])
          REG_CTRL:      fx_q <= {5'b0, mode, en};
          REG_CONST_LO:  fx_q <= const_val[7:0];
          REG_CONST_HI:  fx_q <= const_val[15:8];
          REG_STEP_LO:   fx_q <= step[7:0];
          REG_STEP_HI:   fx_q <= step[15:8];
          REG_ALT_LO:    fx_q <= alt_val[7:0];
          REG_ALT_HI:    fx_q <= alt_val[15:8];
          REG_FRAME_CNT: fx_q <= frame_cnt;
          REG_STATUS:    fx_q <= {6'b0, state};
          default:       fx_q <= '0;
        endcase
      end else begin
        fx_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ad_emu.sv
// Emulated 16-bit serial ADC responder: synchronizes cs_n/sclk and shifts out the programmed word.
module ad_emu
  import ad_emu_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [5:0]  dev_id,
  input  logic        cs_n,
  input  logic        sclk,
  output logic        sdata,
  input  logic [21:0] fx_waddr,
  input  logic        fx_wr,
  input  logic [7:0]  fx_data,
  input  logic [21:0] fx_raddr,
  input  logic        fx_rd,
  output logic [7:0]  fx_q
);

  state_t             state;
  logic [2:0]         cs_sync;
  logic [2:0]         sclk_sync;
  logic [FRAME_W-1:0] shreg;
  logic [3:0]         bit_cnt;
  logic               en;
  logic [FRAME_W-1:0] cur_word;
  logic               cs_fall;
  logic               cs_rise;
  logic               sclk_fall;
  logic               frame_done;

  // [0] metastability flop, [1] synchronized, [2] previous value for edge detect
  assign cs_fall    = cs_sync[2] & ~cs_sync[1];
  assign cs_rise    = ~cs_sync[2] & cs_sync[1];
  assign sclk_fall  = sclk_sync[2] & ~sclk_sync[1];
  assign frame_done = en && (state == ST_DONE) && cs_rise;

  ad_emu_regs u_regs (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .dev_id     (dev_id),
    .fx_waddr   (fx_waddr),
    .fx_wr      (fx_wr),
    .fx_data    (fx_data),
    .fx_raddr   (fx_raddr),
    .fx_rd      (fx_rd),
    .fx_q       (fx_q),
    .state      (state),
    .frame_done (frame_done),
    .en         (en),
    .cur_word   (cur_word)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      sdata     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs_n};
      sclk_sync <= {sclk_sync[1:0], sclk};
      if (!en) begin
        state <= ST_IDLE;
        sdata <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sdata <= 1'b0;
            if (cs_fall) begin
              shreg   <= cur_word;
              sdata   <= cur_word[FRAME_W-1];
              bit_cnt <= '0;
              state   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (cs_rise) begin
              state <= ST_IDLE;
              sdata <= 1'b0;
            end else if (sclk_fall) begin
              shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              sdata   <= shreg[FRAME_W-2];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(FRAME_W - 1))
                state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (cs_rise) begin
              state <= ST_IDLE;
              sdata <= 1'b0;
            end else if (sclk_fall) begin
              shreg <= {shreg[FRAME_W-2:0], 1'b0};
              sdata <= shreg[FRAME_W-2];
            end
          end
          default: begin
            state <= ST_IDLE;
            sdata <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad_emu.sv
// Directed bench for ad_emu: table-driven pattern frames plus hand-written corner sequences.
module tb_ad_emu;
  import ad_emu_pkg::*;

  localparam logic [5:0] DEV = 6'h2A;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [5:0]  dev_id;
  logic        cs_n;
  logic        sclk;
  logic        sdata;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;
  assign dev_id = DEV;

  ad_emu dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .dev_id   (dev_id),
    .cs_n     (cs_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_raddr (fx_raddr),
    .fx_rd    (fx_rd),
    .fx_q     (fx_q)
  );

  typedef struct {
    logic [7:0]       ctrl;
    logic [15:0]      cval;
    logic [15:0]      step;
    logic [15:0]      alt;
    int               nfr;
    logic [3:0][15:0] exp;
    logic [7:0]       exp_cnt;
  } vec_t;

  vec_t vecs [3];

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sclk  = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic fx_write(input logic [7:0] off, input logic [7:0] d);
    fx_waddr = {DEV, 8'h00, off};
    fx_data  = d;
    fx_wr    = 1'b1;
    tick(1);
    fx_wr    = 1'b0;
  endtask

  task automatic fx_read(input logic [5:0] id, input logic [7:0] off, output logic [7:0] q);
    fx_raddr = {id, 8'h00, off};
    fx_rd    = 1'b1;
    tick(1);
    fx_rd    = 1'b0;
    q        = fx_q;
  endtask

  task automatic prog(input logic [7:0] ctrl, input logic [15:0] c, input logic [15:0] s,
                      input logic [15:0] a);
    fx_write(REG_CONST_LO, c[7:0]);
    fx_write(REG_CONST_HI, c[15:8]);
    fx_write(REG_STEP_LO, s[7:0]);
    fx_write(REG_STEP_HI, s[15:8]);
    fx_write(REG_ALT_LO, a[7:0]);
    fx_write(REG_ALT_HI, a[15:8]);
    fx_write(REG_CTRL, ctrl);
    tick(2);
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(8);
  endtask

  // Master samples sdata at each sclk fall, before the emulator reacts to that fall.
  task automatic frame_bits(input int n, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      w    = {w[14:0], sdata};
      tick(8);
      sclk = 1'b1;
      tick(8);
    end
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic full_frame(output logic [15:0] w);
    frame_start();
    frame_bits(16, w);
    frame_end();
  endtask

  logic [15:0] w;
  logic [7:0]  q;

  initial begin
    fx_waddr = '0; fx_raddr = '0; fx_data = '0; fx_wr = 1'b0; fx_rd = 1'b0;

    vecs[0] = '{ctrl: 8'h01, cval: 16'hA5C3, step: 16'h0000, alt: 16'h0000, nfr: 1,
                exp: {16'h0, 16'h0, 16'h0, 16'hA5C3}, exp_cnt: 8'd1};
    vecs[1] = '{ctrl: 8'h03, cval: 16'hFFFE, step: 16'h0001, alt: 16'h0000, nfr: 3,
                exp: {16'h0, 16'h0000, 16'hFFFF, 16'hFFFE}, exp_cnt: 8'd3};
    vecs[2] = '{ctrl: 8'h05, cval: 16'h1234, step: 16'h0000, alt: 16'h8001, nfr: 4,
                exp: {16'h8001, 16'h1234, 16'h8001, 16'h1234}, exp_cnt: 8'd4};

    // Reset state
    do_reset();
    check("reset_sdata", {15'b0, sdata}, 16'h0000);
    fx_read(DEV, REG_STATUS, q);
    check("reset_status", {8'h0, q}, 16'h0000);

    // Pattern table: constant, ramp with wrap, square
    for (int v = 0; v < 3; v++) begin
      do_reset();
      prog(vecs[v].ctrl, vecs[v].cval, vecs[v].step, vecs[v].alt);
      for (int f = 0; f < vecs[v].nfr; f++) begin
        full_frame(w);
        check($sformatf("vec%0d_word%0d", v, f), w, vecs[v].exp[f]);
      end
      fx_read(DEV, REG_FRAME_CNT, q);
      check($sformatf("vec%0d_cnt", v), {8'h0, q}, {8'h0, vecs[v].exp_cnt});
    end

    // sclk fall to sdata latency is 3 clk_sys cycles
    do_reset();
    prog(8'h01, 16'hA5C3, 16'h0, 16'h0);
    frame_start();
    check("lat_first_bit", {15'b0, sdata}, 16'h0001);
    sclk = 1'b0;
    tick(2);
    check("lat_hold", {15'b0, sdata}, 16'h0001);
    tick(1);
    check("lat_change", {15'b0, sdata}, 16'h0000);
    tick(5);
    sclk = 1'b1;
    tick(8);
    frame_bits(15, w);
    frame_end();
    check("lat_rest", {1'b0, w[14:0]}, 16'h25C3);

    // Aborted frame repeats its word; ctrl write coinciding with completion wins
    do_reset();
    prog(8'h03, 16'h0100, 16'h0010, 16'h0);
    frame_start();
    frame_bits(7, w);
    fx_read(DEV, REG_STATUS, q);
    check("abort_status_shift", {8'h0, q}, 16'h0001);
    frame_end();
    fx_read(DEV, REG_FRAME_CNT, q);
    check("abort_cnt", {8'h0, q}, 16'h0000);
    full_frame(w);
    check("abort_repeat_word", w, 16'h0100);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("abort_then_full_cnt", {8'h0, q}, 16'h0001);
    frame_start();
    frame_bits(16, w);
    check("coinc_word", w, 16'h0110);
    fx_read(DEV, REG_STATUS, q);
    check("done_status", {8'h0, q}, 16'h0002);
    cs_n = 1'b1;
    tick(2);
    fx_write(REG_CTRL, 8'h03);
    tick(8);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("coinc_cnt", {8'h0, q}, 16'h0002);
    full_frame(w);
    check("coinc_ctrl_wins", w, 16'h0100);

    // en=0: no output, no count; mismatched dev_id reads 0
    do_reset();
    prog(8'h00, 16'hA5C3, 16'h0, 16'h0);
    full_frame(w);
    check("dis_word", w, 16'h0000);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("dis_cnt", {8'h0, q}, 16'h0000);
    fx_write(REG_CTRL, 8'h01);
    tick(2);
    full_frame(w);
    check("en_word", w, 16'hA5C3);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("en_cnt", {8'h0, q}, 16'h0001);
    fx_read(6'h15, REG_FRAME_CNT, q);
    check("bad_dev_read", {8'h0, q}, 16'h0000);
    fx_read(DEV, REG_CONST_HI, q);
    check("const_hi_read", {8'h0, q}, 16'h00A5);
    fx_read(DEV, 8'h09, q);
    check("unmapped_read", {8'h0, q}, 16'h0000);
    fx_write(REG_FRAME_CNT, 8'h55);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("cnt_read_only", {8'h0, q}, 16'h0001);

    // Clearing en mid-frame returns to idle without counting
    frame_start();
    frame_bits(5, w);
    fx_write(REG_CTRL, 8'h00);
    tick(2);
    fx_read(DEV, REG_STATUS, q);
    check("en_clear_status", {8'h0, q}, 16'h0000);
    check("en_clear_sdata", {15'b0, sdata}, 16'h0000);
    frame_end();
    fx_read(DEV, REG_FRAME_CNT, q);
    check("en_clear_cnt", {8'h0, q}, 16'h0001);

    // Reset at bit 9 of a frame
    do_reset();
    prog(8'h01, 16'hA5C3, 16'h1234, 16'h5678);
    frame_start();
    frame_bits(9, w);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    cs_n  = 1'b1;
    tick(8);
    for (int i = 0; i <= 8; i++) begin
      fx_read(DEV, 8'(i), q);
      check($sformatf("midrst_reg%0d", i), {8'h0, q}, 16'h0000);
    end
    full_frame(w);
    check("midrst_word", w, 16'h0000);
    fx_read(DEV, REG_FRAME_CNT, q);
    check("midrst_cnt", {8'h0, q}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
